cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
- Parametrised multi-cycle control sequencer for the Niski RV32I core.
- Sequences fetch, execute, memory wait and interrupt check.
- Adds what the current core lacks: real interrupt entry over NUM_IRQ level lines, fixed priority, vectored dispatch, EPC/cause capture, MRET return.
- Sits between the decoder/branch tester and the memory access unit, PC register, IR and register file. Drives their write enables and mux selects.

Parameters:
- NUM_IRQ, 8, interrupt line count, 1..32.
- VEC_BASE, 32'h40000100, trap vector base address.
- VECTORED, 1'b1. 1: handler = VEC_BASE + 4*id. 0: all interrupts go to VEC_BASE.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- inst_load, inst_store, inst_jump, inst_mret  in  1 each  decoded class of the current IR.
- branch_taken  in  1  conditional branch resolved taken.
- ma_done  in  1  memory access unit completion.
- pc  in  32  current PC value.
- irq  in  NUM_IRQ  level interrupt requests.
- ie_wr  in  1  write enables.
- ie_data  in  NUM_IRQ+1  value for ie_wr: bit NUM_IRQ = global MIE, low bits = per-line mask.
- ma_rd_req, ma_wr_req  out  1  memory requests.
- ma_sel_inst  out  1  memory address = PC.
- ir_wr  out  1  IR load.
- gpr_wr  out  1  register file write.
- pc_wr  out  1  PC write.
- pc_sel  out  2  next PC source: 0 = PC+4, 1 = branch/jump target, 2 = trap vector, 3 = EPC.
- trap_vec  out  32  vector address.
- epc  out  32  saved return PC.
- cause  out  5  index of the last taken interrupt.
- in_trap  out  1  MIE currently cleared by trap entry.

Behaviour:
- Reset (rst==0 at edge):
  - state = RD_INST_REQ.
  - All request and enable outputs = 0.
  - mie = 0, mpie = 0, mask = 0, epc = 0, cause = 0, pc_changed = 0.
- State RD_INST_REQ: assert ma_sel_inst; set ma_rd_req; go to RD_INST_WAIT; clear pc_changed.
- State RD_INST_WAIT: hold ma_rd_req and ma_sel_inst. On ma_done: ir_wr=1 (combinational), drop ma_rd_req, go to EXEC.
- State EXEC:
  - Load: set ma_rd_req, go to MEM_WAIT.
  - Store: set ma_wr_req, go to MEM_WAIT.
  - Otherwise: gpr_wr=1 unless store or branch, go to CHECK_INTR.
  - inst_jump, or branch_taken: pc_wr=1, pc_sel=1, pc_changed=1.
  - inst_mret: pc_wr=1, pc_sel=3, mie<=mpie, pc_changed=1.
- State MEM_WAIT: on ma_done: gpr_wr=1 if the access was a read; drop both requests; go to CHECK_INTR. ma_done outside RD_INST_WAIT and MEM_WAIT is ignored.
- State CHECK_INTR:
  - If !pc_changed: pc_wr=1, pc_sel=0.
  - pending = irq & mask & {NUM_IRQ{mie}}.
  - pending != 0: go to INTR_ENTER. Otherwise go to RD_INST_REQ.
- State INTR_ENTER:
  - epc<=pc, which by now holds the next instruction address.
  - cause<=lowest set index of pending, re-evaluated this cycle. If pending is now 0, abort to RD_INST_REQ with no side effects.
  - mpie<=mie, mie<=0, pc_wr=1, pc_sel=2, go to RD_INST_REQ.
- trap_vec: combinational from the priority-encoded pending index. 32-bit add, wrap ignored.
- irq is sampled only in CHECK_INTR and INTR_ENTER. Pulses shorter than one instruction can be lost; sources hold until acknowledged in software.
- ie_wr: takes effect the cycle after the write. When it coincides with a trap-entry mie clear, trap entry wins. When it coincides with an mret mie restore, mret wins.
- Latency with zero-wait memory (ma_done in the first wait cycle):
  - ALU instruction: 4 cycles.
  - Load/store: 5 cycles.
  - Interrupt entry: +1 cycle.
- Unencoded state value: go to RD_INST_REQ.
- Reset mid-access drops requests at the same edge.

Optional Feature:
- CPU_WFI_EN defined:
  - New input inst_wfi. EXEC with inst_wfi goes to WFI_SLEEP instead of CHECK_INTR; PC advances as normal.
  - WFI_SLEEP holds with no requests until (irq & mask) != 0, regardless of mie, then goes to CHECK_INTR.
- Undefined: no port, no state; WFI decodes as a NOP.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding (8-bit localparams, extended from the existing state list);
  - pc_sel encodings PC_SEL_SEQ, PC_SEL_TGT, PC_SEL_VEC, PC_SEL_EPC.
- One sub-module, cpu_irq_prio_enc: NUM_IRQ-wide lowest-index priority encoder giving a valid flag and a 5-bit id.

Test Plan:
- Reset, then zero-wait memory: ALU instruction gives ma_rd_req in cycle 1, ir_wr and gpr_wr in cycles 2/3, pc_wr with pc_sel=0 in cycle 4, next fetch in cycle 5.
- Load with ma_done delayed 3 cycles: MEM_WAIT held 3 cycles; gpr_wr pulses exactly once, on the ma_done cycle.
- ie_data=9'h1_0A, irq=8'h0A during an ALU instruction, pc=0x40000010 in INTR_ENTER: epc=0x40000010, cause=1, pc_sel=2, trap_vec=0x40000104, in_trap=1.
- mret after that entry: pc_sel=3, mie restored to 1. irq still 8'h0A, so re-entry happens at the next CHECK_INTR.
- irq dropped between CHECK_INTR and INTR_ENTER: abort with epc and cause unchanged, no pc_wr.
- With CPU_WFI_EN, mie=0, mask=8'h80: WFI sleeps; irq[7]=1 wakes it, no trap taken, next fetch follows.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu sequencer: FSM state codes and next-PC selects.
// The WFI_SLEEP state exists only when CPU_WFI_EN is defined.
package cpu_pkg;

    localparam int unsigned STATE_W = 8;
    localparam int unsigned ID_W    = 5;

    localparam logic [STATE_W-1:0] ST_RD_INST_REQ  = 8'h00;
    localparam logic [STATE_W-1:0] ST_RD_INST_WAIT = 8'h01;
    localparam logic [STATE_W-1:0] ST_EXEC         = 8'h02;
    localparam logic [STATE_W-1:0] ST_MEM_WAIT     = 8'h03;
    localparam logic [STATE_W-1:0] ST_CHECK_INTR   = 8'h04;
    localparam logic [STATE_W-1:0] ST_INTR_ENTER   = 8'h05;
`ifdef CPU_WFI_EN
    localparam logic [STATE_W-1:0] ST_WFI_SLEEP    = 8'h06;
`endif

    typedef enum logic [STATE_W-1:0] {
        S_RD_INST_REQ  = ST_RD_INST_REQ,
        S_RD_INST_WAIT = ST_RD_INST_WAIT,
        S_EXEC         = ST_EXEC,
        S_MEM_WAIT     = ST_MEM_WAIT,
        S_CHECK_INTR   = ST_CHECK_INTR,
`ifdef CPU_WFI_EN
        S_WFI_SLEEP    = ST_WFI_SLEEP,
`endif
        S_INTR_ENTER   = ST_INTR_ENTER
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_TGT = 2'd1;
    localparam logic [1:0] PC_SEL_VEC = 2'd2;
    localparam logic [1:0] PC_SEL_EPC = 2'd3;

endpackage

// File: rtl/cpu_irq_prio_enc.sv
// Fixed-priority encoder over the interrupt lines: the lowest set index wins.
module cpu_irq_prio_enc
    import cpu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scan high to low so the last hit, the lowest index, is kept.
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control sequencer for the Niski RV32I core with vectored interrupt entry and MRET.
// Defining CPU_WFI_EN adds the inst_wfi input and a WFI sleep state.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_IRQ  = 8,
    parameter logic [31:0] VEC_BASE = 32'h40000100,
    parameter bit          VECTORED = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_load,
    input  logic               inst_store,
    input  logic               inst_jump,
    input  logic               inst_mret,
`ifdef CPU_WFI_EN
    input  logic               inst_wfi,
`endif
    input  logic               branch_taken,
    input  logic               ma_done,
    input  logic [31:0]        pc,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               ie_wr,
    input  logic [NUM_IRQ:0]   ie_data,
    output logic               ma_rd_req,
    output logic               ma_wr_req,
    output logic               ma_sel_inst,
    output logic               ir_wr,
    output logic               gpr_wr,
    output logic               pc_wr,
    output logic [1:0]         pc_sel,
    output logic [31:0]        trap_vec,
    output logic [31:0]        epc,
    output logic [4:0]         cause,
    output logic               in_trap
);

    state_t               state;
    logic                 mie;
    logic                 mpie;
    logic [NUM_IRQ-1:0]   mask;
    logic                 pc_changed;
    logic [NUM_IRQ-1:0]   pending;
    logic                 pend_valid;
    logic [ID_W-1:0]      pend_id;

    assign pending = irq & mask & {NUM_IRQ{mie}};

    cpu_irq_prio_enc #(.N(NUM_IRQ)) u_prio (
        .req   (pending),
        .valid (pend_valid),
        .id    (pend_id)
    );

    assign trap_vec = VECTORED ? (VEC_BASE + 32'({pend_id, 2'b00})) : VEC_BASE;

`ifdef CPU_WFI_EN
    logic wake;
    assign wake = |(irq & mask);
`endif

    // State, interrupt CSRs and request flags; requests are set on the edge entering the state that needs them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_RD_INST_REQ;
            ma_rd_req   <= 1'b0;
            ma_wr_req   <= 1'b0;
            ma_sel_inst <= 1'b0;
            mie         <= 1'b0;
            mpie        <= 1'b0;
            mask        <= '0;
            epc         <= '0;
            cause       <= '0;
            pc_changed  <= 1'b0;
            in_trap     <= 1'b0;
        end else begin
            // Software enable write has lowest priority; FSM updates below override it.
            if (ie_wr) begin
                mie  <= ie_data[NUM_IRQ];
                mask <= ie_data[NUM_IRQ-1:0];
                if (ie_data[NUM_IRQ]) begin
                    in_trap <= 1'b0;
                end
            end

            case (state)
                S_RD_INST_REQ: begin
                    ma_rd_req   <= 1'b1;
                    ma_sel_inst <= 1'b1;
                    pc_changed  <= 1'b0;
                    state       <= S_RD_INST_WAIT;
                end
                S_RD_INST_WAIT: begin
                    if (ma_done) begin
                        ma_rd_req   <= 1'b0;
                        ma_sel_inst <= 1'b0;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (inst_mret) begin
                        mie        <= mpie;
                        in_trap    <= 1'b0;
                        pc_changed <= 1'b1;
                    end else if (inst_jump || branch_taken) begin
                        pc_changed <= 1'b1;
                    end
                    if (inst_load) begin
                        ma_rd_req <= 1'b1;
                        state     <= S_MEM_WAIT;
                    end else if (inst_store) begin
                        ma_wr_req <= 1'b1;
                        state     <= S_MEM_WAIT;
                    end
`ifdef CPU_WFI_EN
                    else if (inst_wfi) begin
                        state <= S_WFI_SLEEP;
                    end
`endif
                    else begin
                        state <= S_CHECK_INTR;
                    end
                end
                S_MEM_WAIT: begin
                    if (ma_done) begin
                        ma_rd_req <= 1'b0;
                        ma_wr_req <= 1'b0;
                        state     <= S_CHECK_INTR;
                    end
                end
                S_CHECK_INTR: begin
                    if (pend_valid) begin
                        state <= S_INTR_ENTER;
                    end else begin
                        ma_rd_req   <= 1'b1;
                        ma_sel_inst <= 1'b1;
                        state       <= S_RD_INST_REQ;
                    end
                end
                S_INTR_ENTER: begin
                    // Request may have dropped since CHECK_INTR; then just resume fetching.
                    if (pend_valid) begin
                        epc     <= pc;
                        cause   <= pend_id;
                        mpie    <= mie;
                        mie     <= 1'b0;
                        in_trap <= 1'b1;
                    end
                    ma_rd_req   <= 1'b1;
                    ma_sel_inst <= 1'b1;
                    state       <= S_RD_INST_REQ;
                end
`ifdef CPU_WFI_EN
                S_WFI_SLEEP: begin
                    if (wake) begin
                        state <= S_CHECK_INTR;
                    end
                end
`endif
                default: begin
                    ma_rd_req   <= 1'b0;
                    ma_wr_req   <= 1'b0;
                    ma_sel_inst <= 1'b0;
                    state       <= S_RD_INST_REQ;
                end
            endcase
        end
    end

    // Single-cycle write strobes and PC select, decoded from the current state.
    always_comb begin
        ir_wr  = 1'b0;
        gpr_wr = 1'b0;
        pc_wr  = 1'b0;
        pc_sel = PC_SEL_SEQ;
        case (state)
            S_RD_INST_WAIT: ir_wr = ma_done;
            S_EXEC: begin
                if (!inst_load && !inst_store) begin
                    gpr_wr = !branch_taken;
                end
                if (inst_mret) begin
                    pc_wr  = 1'b1;
                    pc_sel = PC_SEL_EPC;
                end else if (inst_jump || branch_taken) begin
                    pc_wr  = 1'b1;
                    pc_sel = PC_SEL_TGT;
                end
            end
            S_MEM_WAIT:   gpr_wr = ma_done && ma_rd_req;
            S_CHECK_INTR: pc_wr  = !pc_changed;
            S_INTR_ENTER: begin
                if (pend_valid) begin
                    pc_wr  = 1'b1;
                    pc_sel = PC_SEL_VEC;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: table of single instructions scored through a queue,
// plus hand sequences for interrupt entry, MRET, abort, priority, WFI and mid-access reset.
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_load, inst_store, inst_jump, inst_mret, branch_taken;
`ifdef CPU_WFI_EN
    logic        inst_wfi;
`endif
    logic        ma_done;
    logic [31:0] pc;
    logic [7:0]  irq;
    logic        ie_wr;
    logic [8:0]  ie_data;
    logic        ma_rd_req, ma_wr_req, ma_sel_inst, ir_wr, gpr_wr, pc_wr;
    logic [1:0]  pc_sel;
    logic [31:0] trap_vec, epc;
    logic [4:0]  cause;
    logic        in_trap;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    cpu_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .inst_load    (inst_load),
        .inst_store   (inst_store),
        .inst_jump    (inst_jump),
        .inst_mret    (inst_mret),
`ifdef CPU_WFI_EN
        .inst_wfi     (inst_wfi),
`endif
        .branch_taken (branch_taken),
        .ma_done      (ma_done),
        .pc           (pc),
        .irq          (irq),
        .ie_wr        (ie_wr),
        .ie_data      (ie_data),
        .ma_rd_req    (ma_rd_req),
        .ma_wr_req    (ma_wr_req),
        .ma_sel_inst  (ma_sel_inst),
        .ir_wr        (ir_wr),
        .gpr_wr       (gpr_wr),
        .pc_wr        (pc_wr),
        .pc_sel       (pc_sel),
        .trap_vec     (trap_vec),
        .epc          (epc),
        .cause        (cause),
        .in_trap      (in_trap)
    );

    typedef struct {
        string    name;
        bit       ld, st, jmp, mr, tk;
        int       lat;      // MEM_WAIT cycles until ma_done
        bit       spur;     // extra ma_done pulses in states that must ignore them
        int       cyc;      // cycles from fetch request to next fetch request
        int       gpr;      // gpr_wr pulses
        int       gcyc;     // cycle of the gpr_wr pulse (0 = none)
        int       pcwr;     // pc_wr pulses
        logic [1:0] sel;    // pc_sel on the last pc_wr
        int       rd, wr;   // cycles with ma_rd_req / ma_wr_req high
    } vec_t;

    vec_t vecs[11];
    vec_t sb_q[$];

    function automatic vec_t mk(input string n, input bit ld, input bit st, input bit jmp,
                                input bit mr, input bit tk, input int lat, input bit spur,
                                input int cyc, input int gpr, input int gcyc, input int pcwr,
                                input logic [1:0] sel, input int rd, input int wr);
        vec_t v;
        v.name = n; v.ld = ld; v.st = st; v.jmp = jmp; v.mr = mr; v.tk = tk;
        v.lat = lat; v.spur = spur; v.cyc = cyc; v.gpr = gpr; v.gcyc = gcyc;
        v.pcwr = pcwr; v.sel = sel; v.rd = rd; v.wr = wr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one instruction starting in a fetch-request cycle and ends in the next one.
    task automatic run_vec(input vec_t v);
        vec_t e;
        int c, gpr_cnt, gpr_cyc, ir_cnt, ir_cyc, pcwr_cnt, rd_cnt, wr_cnt, cycles;
        logic [1:0] sel;
        logic prev_sel;
        bit fin, mem;
        sb_q.push_back(v);
        inst_load = v.ld; inst_store = v.st; inst_jump = v.jmp;
        inst_mret = v.mr; branch_taken = v.tk;
        mem = v.ld || v.st;
        c = 1; gpr_cnt = 0; gpr_cyc = 0; ir_cnt = 0; ir_cyc = 0; pcwr_cnt = 0;
        rd_cnt = 0; wr_cnt = 0; cycles = 0; sel = 2'd0; prev_sel = 1'b0; fin = 1'b0;
        while (!fin) begin
            ma_done = (c == 2) || (mem && c == 3 + v.lat) ||
                      (v.spur && (c == 1 || c == 3 || (!mem && c == 4)));
            #1;
            if (c >= 3 && ma_sel_inst && !prev_sel) begin
                fin = 1'b1;
                cycles = c - 1;
            end else begin
                if (gpr_wr) begin gpr_cnt++; gpr_cyc = c; end
                if (ir_wr)  begin ir_cnt++;  ir_cyc  = c; end
                if (pc_wr)  begin pcwr_cnt++; sel = pc_sel; end
                if (ma_rd_req) rd_cnt++;
                if (ma_wr_req) wr_cnt++;
                prev_sel = ma_sel_inst;
                if (c >= 40) begin
                    fin = 1'b1;
                    cycles = c;
                end else begin
                    @(negedge clk);
                    c++;
                end
            end
        end
        ma_done = 1'b0;
        e = sb_q.pop_front();
        chk({e.name, " cycles"},   32'(cycles),   32'(e.cyc));
        chk({e.name, " ir_cnt"},   32'(ir_cnt),   32'd1);
        chk({e.name, " ir_cyc"},   32'(ir_cyc),   32'd2);
        chk({e.name, " gpr_cnt"},  32'(gpr_cnt),  32'(e.gpr));
        chk({e.name, " gpr_cyc"},  32'(gpr_cyc),  32'(e.gcyc));
        chk({e.name, " pcwr_cnt"}, 32'(pcwr_cnt), 32'(e.pcwr));
        chk({e.name, " pc_sel"},   32'(sel),      32'(e.sel));
        chk({e.name, " rd_cyc"},   32'(rd_cnt),   32'(e.rd));
        chk({e.name, " wr_cyc"},   32'(wr_cnt),   32'(e.wr));
    endtask

    task automatic clr_inst();
        inst_load = 1'b0; inst_store = 1'b0; inst_jump = 1'b0;
        inst_mret = 1'b0; branch_taken = 1'b0;
`ifdef CPU_WFI_EN
        inst_wfi = 1'b0;
`endif
    endtask

    initial begin
        vecs[0]  = mk("alu",      0,0,0,0,0, 0,0, 4,1,3,1,2'd0,2,0);
        vecs[1]  = mk("load1",    1,0,0,0,0, 1,0, 5,1,4,1,2'd0,3,0);
        vecs[2]  = mk("load3",    1,0,0,0,0, 3,0, 7,1,6,1,2'd0,5,0);
        vecs[3]  = mk("store1",   0,1,0,0,0, 1,0, 5,0,0,1,2'd0,2,1);
        vecs[4]  = mk("store2",   0,1,0,0,0, 2,0, 6,0,0,1,2'd0,2,2);
        vecs[5]  = mk("jump",     0,0,1,0,0, 0,0, 4,1,3,1,2'd1,2,0);
        vecs[6]  = mk("branch",   0,0,0,0,1, 0,0, 4,0,0,1,2'd1,2,0);
        vecs[7]  = mk("mret0",    0,0,0,1,0, 0,0, 4,1,3,1,2'd3,2,0);
        vecs[8]  = mk("alu_spur", 0,0,0,0,0, 0,1, 4,1,3,1,2'd0,2,0);
        vecs[9]  = mk("ld_jump",  1,0,1,0,0, 1,0, 5,1,4,1,2'd1,3,0);
        vecs[10] = mk("ld3_spur", 1,0,0,0,0, 3,1, 7,1,6,1,2'd0,5,0);

        rst = 1'b0; clr_inst(); ma_done = 1'b0; pc = 32'h0;
        irq = 8'h00; ie_wr = 1'b0; ie_data = 9'h000;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst ma_rd_req",   32'(ma_rd_req),   32'd0);
        chk("rst ma_wr_req",   32'(ma_wr_req),   32'd0);
        chk("rst ma_sel_inst", 32'(ma_sel_inst), 32'd0);
        chk("rst gpr_wr",      32'(gpr_wr),      32'd0);
        chk("rst pc_wr",       32'(pc_wr),       32'd0);
        chk("rst epc",         epc,              32'd0);
        chk("rst cause",       32'(cause),       32'd0);
        chk("rst in_trap",     32'(in_trap),     32'd0);
        rst = 1'b1;
        // First instruction after reset: the request rises on entry to the wait state.
        @(negedge clk); ma_done = 1'b1; #1;
        chk("boot rd_req", 32'(ma_rd_req),   32'd1);
        chk("boot sel",    32'(ma_sel_inst), 32'd1);
        chk("boot ir_wr",  32'(ir_wr),       32'd1);
        @(negedge clk); ma_done = 1'b0; #1;
        chk("boot gpr_wr", 32'(gpr_wr), 32'd1);
        @(negedge clk); #1;
        chk("boot pc_wr",  32'(pc_wr),  32'd1);
        chk("boot pc_sel", 32'(pc_sel), 32'd0);
        @(negedge clk); #1;
        chk("boot refetch", 32'(ma_rd_req & ma_sel_inst), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);
        clr_inst();

        // Interrupt entry: mie=1, mask=0x0A, irq=0x0A -> id 1
        ie_wr = 1'b1; ie_data = 9'h10A; irq = 8'h0A;
        @(negedge clk); ie_wr = 1'b0; ma_done = 1'b1;
        @(negedge clk); ma_done = 1'b0;
        @(negedge clk); #1;
        chk("irq check pc_wr",  32'(pc_wr),  32'd1);
        chk("irq check pc_sel", 32'(pc_sel), 32'd0);
        @(negedge clk); pc = 32'h40000010; #1;
        chk("irq enter pc_wr",  32'(pc_wr),  32'd1);
        chk("irq enter pc_sel", 32'(pc_sel), 32'd2);
        chk("irq trap_vec",     trap_vec,    32'h40000104);
        @(negedge clk); #1;
        chk("irq epc",     epc,              32'h40000010);
        chk("irq cause",   32'(cause),       32'd1);
        chk("irq in_trap", 32'(in_trap),     32'd1);
        chk("irq refetch", 32'(ma_sel_inst), 32'd1);

        // MRET restores mie; irq still high, so the next check re-enters
        inst_mret = 1'b1;
        @(negedge clk); ma_done = 1'b1;
        @(negedge clk); ma_done = 1'b0; #1;
        chk("mret pc_wr",  32'(pc_wr),  32'd1);
        chk("mret pc_sel", 32'(pc_sel), 32'd3);
        @(negedge clk); #1;
        chk("mret check pc_wr", 32'(pc_wr),   32'd0);
        chk("mret in_trap",     32'(in_trap), 32'd0);
        @(negedge clk); inst_mret = 1'b0; pc = 32'h40000020; #1;
        chk("reenter pc_sel",   32'(pc_sel), 32'd2);
        chk("reenter trap_vec", trap_vec,    32'h40000104);
        @(negedge clk); #1;
        chk("reenter epc",     epc,          32'h40000020);
        chk("reenter in_trap", 32'(in_trap), 32'd1);

        // irq drops between CHECK_INTR and INTR_ENTER: abort without side effects
        ie_wr = 1'b1; ie_data = 9'h10A;
        @(negedge clk); ie_wr = 1'b0; ma_done = 1'b1;
        @(negedge clk); ma_done = 1'b0;
        @(negedge clk);
        @(negedge clk); irq = 8'h00; pc = 32'h40000030; #1;
        chk("abort pc_wr",    32'(pc_wr),       32'd0);
        chk("abort in enter", 32'(ma_sel_inst), 32'd0);
        chk("abort trap_vec", trap_vec,         32'h40000100);
        @(negedge clk); #1;
        chk("abort refetch",  32'(ma_sel_inst), 32'd1);
        chk("abort epc",      epc,              32'h40000020);
        chk("abort cause",    32'(cause),       32'd1);
        chk("abort in_trap",  32'(in_trap),     32'd0);

        // Priority: irq 0x88 -> id 3; ie_wr during entry loses to the mie clear
        ie_wr = 1'b1; ie_data = 9'h1FF; irq = 8'h88;
        @(negedge clk); ie_wr = 1'b0; ma_done = 1'b1;
        @(negedge clk); ma_done = 1'b0;
        @(negedge clk);
        @(negedge clk); pc = 32'h40000040; ie_wr = 1'b1; ie_data = 9'h1FF; #1;
        chk("prio pc_sel",   32'(pc_sel), 32'd2);
        chk("prio trap_vec", trap_vec,    32'h4000010C);
        @(negedge clk); ie_wr = 1'b0; #1;
        chk("prio cause",   32'(cause),   32'd3);
        chk("prio epc",     epc,          32'h40000040);
        chk("prio in_trap", 32'(in_trap), 32'd1);
        @(negedge clk); ma_done = 1'b1;
        @(negedge clk); ma_done = 1'b0;
        @(negedge clk); #1;
        chk("masked check pc_wr", 32'(pc_wr), 32'd1);
        @(negedge clk); #1;
        chk("masked no entry", 32'(ma_sel_inst), 32'd1);
        irq = 8'h00;

`ifdef CPU_WFI_EN
        // WFI with mie=0, mask=0x80: only irq[7] wakes, no trap taken
        inst_wfi = 1'b1; ie_wr = 1'b1; ie_data = 9'h080;
        @(negedge clk); ie_wr = 1'b0; ma_done = 1'b1;
        @(negedge clk); ma_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); irq = 8'h01; #1;
            chk("wfi sleep rd_req", 32'(ma_rd_req),   32'd0);
            chk("wfi sleep sel",    32'(ma_sel_inst), 32'd0);
            chk("wfi sleep pc_wr",  32'(pc_wr),       32'd0);
        end
        irq = 8'h80;
        @(negedge clk); inst_wfi = 1'b0; #1;
        chk("wfi wake pc_wr",  32'(pc_wr),  32'd1);
        chk("wfi wake pc_sel", 32'(pc_sel), 32'd0);
        @(negedge clk); #1;
        chk("wfi refetch", 32'(ma_sel_inst), 32'd1);
        chk("wfi cause",   32'(cause),       32'd3);
        chk("wfi epc",     epc,              32'h40000040);
        irq = 8'h00;
`endif

        // Reset in MEM_WAIT drops the request at the same edge
        inst_load = 1'b1;
        @(negedge clk); ma_done = 1'b1;
        @(negedge clk); ma_done = 1'b0;
        @(negedge clk); #1;
        chk("midrst rd_req before", 32'(ma_rd_req), 32'd1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("midrst rd_req",  32'(ma_rd_req),   32'd0);
        chk("midrst sel",     32'(ma_sel_inst), 32'd0);
        chk("midrst epc",     epc,              32'd0);
        chk("midrst cause",   32'(cause),       32'd0);
        chk("midrst in_trap", 32'(in_trap),     32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
